// File: rtl/pick_place_commander_if.sv
// Handshake and control bundle between planner, commander and pick/place block.
// No logic: wires only.
// master is the planner/servo side, slave is the commander.
interface pick_place_commander_if;
  logic       cmd_valid;
  logic       cmd_op;
  logic       cmd_ready;
  logic       pp_start;
  logic [5:0] pp_arm_movement;
  logic [1:0] pp_done;
  logic       rsp_valid;
  logic [1:0] rsp_code;
  logic       holding;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, pp_done,
    input  cmd_ready, pp_start, pp_arm_movement, rsp_valid, rsp_code, holding, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, pp_done,
    output cmd_ready, pp_start, pp_arm_movement, rsp_valid, rsp_code, holding, busy
  );
endinterface

// File: rtl/pick_place_commander.sv
// Issues one pick/place job at a time to the servo block and reports ok/rejected/timeout.
// Latency: accept -> pp_start 2 cycles; qualifying pp_done -> rsp_valid 1 cycle.
// Backpressure: cmd_ready low while a job runs; responses have no back-pressure.
module pick_place_commander #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned REARM_CYCLES   = 1_000,
  parameter int unsigned CNT_W          = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pick_place_commander_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, REARM} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RA_LAST = CNT_W'(REARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             arm_q, arm_d;          // only bit 0 of pp_arm_movement is ever nonzero
  logic             cmd_ready_q, cmd_ready_d;
  logic             pp_start_q, pp_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_code_q, rsp_code_d;
  logic             holding_q, holding_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic [1:0]       exp_done;

  assign accept   = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
  // pick completes with code 1, place with code 2
  assign exp_done = op_q ? 2'd2 : 2'd1;

  // State and all output registers; reset aborts any job silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      arm_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      pp_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= 2'd0;
      holding_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      arm_q       <= arm_d;
      cmd_ready_q <= cmd_ready_d;
      pp_start_q  <= pp_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      holding_q   <= holding_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead so they leave registered
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    arm_d       = arm_q;
    cmd_ready_d = 1'b0;
    pp_start_d  = pp_start_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    holding_d   = holding_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          op_d        = bus.cmd_op;
          // pick needs an empty claw, place needs a full one
          if (bus.cmd_op != holding_q) begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = 2'd1;
          end else begin
            // movement code set a cycle ahead of pp_start and held for the job
            arm_d   = bus.cmd_op;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        pp_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        pp_start_d = 1'b1;
        // completion is checked first so it wins over a simultaneous timeout
        if (bus.pp_done == exp_done) begin
          pp_start_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = 2'd0;
          holding_d   = ~op_q;
          cnt_d       = '0;
          state_d     = REARM;
        end else if (cnt_q >= TO_LAST) begin
          pp_start_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = 2'd2;
          cnt_d       = '0;
          state_d     = REARM;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REARM: begin
        // start held low a full rearm period; pp_done ignored here
        pp_start_d = 1'b0;
        if (cnt_q >= RA_LAST) begin
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.pp_start        = pp_start_q;
  assign bus.pp_arm_movement = {5'd0, arm_q};
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_code        = rsp_code_q;
  assign bus.holding         = holding_q;
  assign bus.busy            = busy_q;

endmodule

// File: tb/tb_pick_place_commander.sv
// Directed bench for pick_place_commander: job table plus hand-written reset sequences.
// Responder pulses pp_done a set number of cycles after pp_start rises.
// Outputs are sampled on the falling clock edge.
module tb_pick_place_commander;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cur_row = -1;

  pick_place_commander_if bus();

  pick_place_commander #(
    .TIMEOUT_CYCLES(200),
    .REARM_CYCLES  (8),
    .CNT_W         (30)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       op;        // 0 pick, 1 place
    logic       started;   // 0 means the interlock must reject it
    int         p1_at;     // cycles after pp_start rise, -1 = none
    logic [1:0] p1_code;
    int         p2_at;
    logic [1:0] p2_code;
    logic [1:0] exp_code;
    logic       exp_hold;
    int         exp_lat;   // falling edges from pp_start high to rsp_valid
  } job_t;

  job_t jobs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, cur_row, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 50), 32'd1);
  endtask

  task automatic run_job(input job_t j);
    int         rsp_cnt;
    int         k;
    logic       seen;
    logic       bad;
    logic       ready_bad;
    logic [5:0] arm0;

    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = j.op;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("ready_drop", 32'(bus.cmd_ready), 32'd0);
    rsp_cnt = 0;
    bad     = 1'b0;

    if (!j.started) begin
      chk("rej_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rej_code", 32'(bus.rsp_code), 32'd1);
      chk("rej_busy", 32'(bus.busy), 32'd0);
      rsp_cnt = 32'(bus.rsp_valid);
      bad     = bus.pp_start;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        rsp_cnt += 32'(bus.rsp_valid);
        bad     |= bus.pp_start;
        if (i == 0) chk("rej_ready_back", 32'(bus.cmd_ready), 32'd1);
      end
      chk("rej_pulses", 32'(rsp_cnt), 32'd1);
      chk("rej_start_low", 32'(bad), 32'd0);
      chk("rej_hold", 32'(bus.holding), 32'(j.exp_hold));
    end else begin
      chk("issue_start_low", 32'(bus.pp_start), 32'd0);
      @(negedge clk);
      chk("start_rise", 32'(bus.pp_start), 32'd1);
      chk("arm", 32'(bus.pp_arm_movement), 32'({5'd0, j.op}));
      chk("busy_job", 32'(bus.busy), 32'd1);
      arm0 = bus.pp_arm_movement;
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 260) begin
        if (bus.rsp_valid === 1'b1) begin
          seen = 1'b1;
          rsp_cnt++;
        end else begin
          if (bus.pp_start !== 1'b1 || bus.pp_arm_movement !== arm0) bad = 1'b1;
          if (k == j.p1_at)      bus.pp_done = j.p1_code;
          else if (k == j.p2_at) bus.pp_done = j.p2_code;
          else                   bus.pp_done = 2'd0;
          @(negedge clk);
          k++;
        end
      end
      chk("rsp_seen", 32'(seen), 32'd1);
      chk("rsp_latency", 32'(k), 32'(j.exp_lat));
      chk("rsp_code", 32'(bus.rsp_code), 32'(j.exp_code));
      chk("hold", 32'(bus.holding), 32'(j.exp_hold));
      chk("start_fall", 32'(bus.pp_start), 32'd0);
      chk("job_stable", 32'(bad), 32'd0);
      // REARM: offer a matching pp_done that must be ignored; ready stays low 8 cycles
      ready_bad = bus.cmd_ready;
      bad       = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        bus.pp_done = (i == 1) ? (j.op ? 2'd2 : 2'd1) : 2'd0;
        @(negedge clk);
        rsp_cnt += 32'(bus.rsp_valid);
        bad     |= bus.pp_start;
        if (i < 8) ready_bad |= bus.cmd_ready;
      end
      bus.pp_done = 2'd0;
      chk("rearm_ready_low", 32'(ready_bad), 32'd0);
      chk("rearm_start_low", 32'(bad), 32'd0);
      chk("rearm_ready_back", 32'(bus.cmd_ready), 32'd1);
      chk("rearm_busy_clear", 32'(bus.busy), 32'd0);
      chk("rsp_pulses", 32'(rsp_cnt), 32'd1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {22'd0, bus.cmd_ready, bus.pp_start, bus.pp_arm_movement,
                          bus.rsp_valid, bus.holding, bus.busy}, 32'd0);
    chk({tag, "_code"}, 32'(bus.rsp_code), 32'd0);
  endtask

  initial begin
    int rsp_cnt;
    job_t post;

    //            op    strt  p1  c1    p2   c2    code  hold lat
    jobs[0] = '{1'b0, 1'b1, 50, 2'd1, -1, 2'd0, 2'd0, 1'b1, 51};   // pick ok
    jobs[1] = '{1'b0, 1'b0, -1, 2'd0, -1, 2'd0, 2'd1, 1'b1, 0};    // pick while holding
    jobs[2] = '{1'b1, 1'b1, 30, 2'd2, -1, 2'd0, 2'd0, 1'b0, 31};   // place ok
    jobs[3] = '{1'b1, 1'b0, -1, 2'd0, -1, 2'd0, 2'd1, 1'b0, 0};    // place while empty
    jobs[4] = '{1'b0, 1'b1, -1, 2'd0, -1, 2'd0, 2'd2, 1'b0, 200};  // timeout
    jobs[5] = '{1'b0, 1'b1, 10, 2'd2, 40, 2'd1, 2'd0, 1'b1, 41};   // wrong code ignored
    jobs[6] = '{1'b1, 1'b1, 5,  2'd1, 199, 2'd2, 2'd0, 1'b0, 200}; // completion beats timeout
    jobs[7] = '{1'b0, 1'b1, 0,  2'd1, -1, 2'd0, 2'd0, 1'b1, 1};    // immediate done
    jobs[8] = '{1'b0, 1'b0, -1, 2'd0, -1, 2'd0, 2'd1, 1'b1, 0};    // reject leaves code 1

    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.pp_done   = 2'd0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    for (int r = 0; r < 9; r++) begin
      cur_row = r;
      run_job(jobs[r]);
    end

    // Async reset in the middle of a place job (holding=1, arm=1, last code=1)
    cur_row = 100;
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_start", 32'(bus.pp_start), 32'd1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    rsp_cnt = 0;
    bus.pp_done = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rsp_cnt += 32'(bus.rsp_valid);
    end
    bus.pp_done = 2'd0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rsp_cnt += 32'(bus.rsp_valid);
    end
    chk("midreset_no_rsp", 32'(rsp_cnt), 32'd0);
    chk("midreset_hold", 32'(bus.holding), 32'd0);

    cur_row = 101;
    post = '{1'b0, 1'b1, 15, 2'd1, -1, 2'd0, 2'd0, 1'b1, 16};
    run_job(post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
